// File: rtl/byte_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared size encodings, state type and helpers for byte_lsu.
//  Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } lsu_state_t;

    // Reserved size reports one beat so beats_of()-1 never underflows.
    function automatic logic [2:0] beats_of(input logic [1:0] size);
        case (size)
            SZ_HALF: beats_of = 3'd2;
            SZ_WORD: beats_of = 3'd4;
            default: beats_of = 3'd1;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = addr_lo[0];
            SZ_WORD: is_misaligned = (addr_lo != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_lsu_extend.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_extend
//  Purpose  : Sign/zero extension of assembled load data by access size.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = i_data;
        case (i_size)
            SZ_BYTE: o_data = {{24{i_signed & i_data[7]}},  i_data[7:0]};
            SZ_HALF: o_data = {{16{i_signed & i_data[15]}}, i_data[15:0]};
            default: o_data = i_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/byte_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : byte_lsu
//  Purpose  : MEM-stage load/store unit serialising byte/half/word accesses
//             into single-byte beats on a byte-wide registered-read RAM.
//  Revision : 1.0 - initial release
// ============================================================================
module byte_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout
);

    lsu_state_t        state_q, state_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        beat_q, beat_d;
    logic [1:0]        last_q, last_d;
    logic              cap_vld_q, cap_vld_d;
    logic [1:0]        cap_idx_q, cap_idx_d;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              w_accept;
    logic [31:0]       w_ext_data;

    assign w_accept = req_ready & req_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            size_q      <= '0;
            signed_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            beat_q      <= '0;
            last_q      <= '0;
            cap_vld_q   <= 1'b0;
            cap_idx_q   <= '0;
            asm_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            beat_q      <= beat_d;
            last_q      <= last_d;
            cap_vld_q   <= cap_vld_d;
            cap_idx_q   <= cap_idx_d;
            asm_q       <= asm_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Read data trails its address by one cycle, so capture is tagged with
    // the beat index that was presented in the previous cycle.
    always_comb begin
        cap_vld_d = (state_q == ST_READ);
        cap_idx_d = beat_q;
        asm_d     = asm_q;
        if (w_accept) begin
            asm_d = '0;
        end else if (cap_vld_q) begin
            asm_d[{cap_idx_q, 3'b000} +: 8] = mem_dout;
        end
    end

    lsu_extend u_extend (
        .i_data   (asm_d),
        .i_size   (size_q),
        .i_signed (signed_q),
        .o_data   (w_ext_data)
    );

    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        signed_d    = signed_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        beat_d      = beat_q;
        last_d      = last_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    beat_d   = '0;
                    last_d   = 2'(beats_of(req_size) - 3'd1);
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        state_d     = ST_DONE;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d = req_we ? ST_WRITE : ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                if (beat_q == last_q) begin
                    state_d     = ST_DONE;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            ST_READ: begin
                if (beat_q == last_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            ST_DRAIN: begin
                // Final byte lands this edge; extend from the next-state value.
                state_d     = ST_DONE;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = w_ext_data;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_we    = (state_q == ST_WRITE);
    assign mem_adr   = ((state_q == ST_WRITE) || (state_q == ST_READ))
                       ? (addr_q + ADDR_W'(beat_q)) : '0;
    assign mem_din   = (state_q == ST_WRITE) ? wdata_q[{beat_q, 3'b000} +: 8] : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_byte_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_byte_lsu
//  Purpose  : Scoreboard bench for byte_lsu with a registered-read byte RAM.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_byte_lsu;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_signed = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_adr;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout = 8'h00;

    logic [7:0] ram [0:(1<<ADDR_W)-1] = '{default: 8'h00};

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   busy_ready = 0;

    always #5 clk = ~clk;

    byte_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_we     (mem_we),
        .mem_adr    (mem_adr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    always @(posedge clk) begin
        if (mem_we) ram[mem_adr] <= mem_din;
        mem_dout <= ram[mem_adr];
        cyc      <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.tag, "_rdata"}, rsp_rdata, mon_e.rdata);
                check({mon_e.tag, "_err"}, 32'(rsp_err), 32'(mon_e.err));
                check({mon_e.tag, "_lat"}, 32'(cyc - mon_e.t0 + 1), 32'(mon_e.lat));
            end
        end
        if (sb.size() != 0 && req_ready) busy_ready++;
    end

    function automatic int beats(input logic [1:0] size);
        return (size == 2'b10) ? 4 : (size == 2'b01) ? 2 : 1;
    endfunction

    task automatic issue(input string tag, input logic we, input logic [1:0] size,
                         input logic sgn, input logic [ADDR_W-1:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input bit keep, output int t0);
        int   n;
        exp_t e;
        @(negedge clk);
        req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check({tag, "_accept_timeout"}, 32'd0, 32'd1);
            req_valid = 1'b0;
            t0 = cyc;
            return;
        end
        @(posedge clk);
        #1;
        t0      = cyc;
        e.tag   = tag;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = exp_err ? 1 : (we ? beats(size) + 1 : beats(size) + 2);
        e.t0    = t0;
        sb.push_back(e);
        if (!keep) begin
            req_valid  = 1'b0;
            req_we     = 1'($urandom);
            req_size   = 2'($urandom);
            req_signed = 1'($urandom);
            req_addr   = ADDR_W'($urandom);
            req_wdata  = $urandom;
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check({tag, "_rsp_timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    logic [1:0]        err_size [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
    logic [ADDR_W-1:0] err_addr [4] = '{12'h003, 12'h006, 12'h008, 12'h006};
    logic              err_we   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int t0, t1;
        logic [31:0] wd;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_adr", 32'(mem_adr), 32'd0);
        check("rst_mem_din", 32'(mem_din), 32'd0);
        rst_n = 1'b1;

        // Store word: four write beats, little-endian
        wd = 32'hDEAD_BEEF;
        issue("st_w", 1'b1, 2'b10, 1'b0, 12'h010, wd, 32'd0, 1'b0, 1'b0, t0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("st_w_we%0d", k), 32'(mem_we), 32'd1);
            check($sformatf("st_w_adr%0d", k), 32'(mem_adr), 32'h010 + 32'(k));
            check($sformatf("st_w_din%0d", k), 32'(mem_din), 32'(wd[8*k +: 8]));
        end
        wait_done("st_w");
        check("ram_010", 32'(ram[12'h010]), 32'hEF);
        check("ram_011", 32'(ram[12'h011]), 32'hBE);
        check("ram_012", 32'(ram[12'h012]), 32'hAD);
        check("ram_013", 32'(ram[12'h013]), 32'hDE);

        issue("ld_w", 1'b0, 2'b10, 1'b0, 12'h010, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, t0);
        wait_done("ld_w");
        check("hold_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check("hold_valid", 32'(rsp_valid), 32'd0);

        issue("st_b", 1'b1, 2'b00, 1'b0, 12'h005, 32'h1234_5680, 32'd0, 1'b0, 1'b0, t0);
        wait_done("st_b");
        check("ram_005", 32'(ram[12'h005]), 32'h80);
        check("ram_006", 32'(ram[12'h006]), 32'h00);
        issue("ld_bs", 1'b0, 2'b00, 1'b1, 12'h005, 32'd0, 32'hFFFF_FF80, 1'b0, 1'b0, t0);
        wait_done("ld_bs");
        issue("ld_bu", 1'b0, 2'b00, 1'b0, 12'h005, 32'd0, 32'h0000_0080, 1'b0, 1'b0, t0);
        wait_done("ld_bu");

        issue("st_h", 1'b1, 2'b01, 1'b0, 12'h020, 32'h7777_A55A, 32'd0, 1'b0, 1'b0, t0);
        wait_done("st_h");
        issue("ld_hs", 1'b0, 2'b01, 1'b1, 12'h020, 32'd0, 32'hFFFF_A55A, 1'b0, 1'b0, t0);
        wait_done("ld_hs");
        issue("ld_hu", 1'b0, 2'b01, 1'b0, 12'h020, 32'd0, 32'h0000_A55A, 1'b0, 1'b0, t0);
        wait_done("ld_hu");

        // Misaligned / reserved: immediate error, RAM untouched
        for (int i = 0; i < 4; i++) begin
            issue($sformatf("err%0d", i), err_we[i], err_size[i], 1'b1, err_addr[i],
                  32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, t0);
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                check($sformatf("err%0d_we_c%0d", i, c), 32'(mem_we), 32'd0);
                check($sformatf("err%0d_adr_c%0d", i, c), 32'(mem_adr), 32'd0);
            end
            wait_done($sformatf("err%0d", i));
        end
        check("err_ram_006", 32'(ram[12'h006]), 32'h00);

        // Reset during a word store: two bytes land, no response
        issue("st_abort", 1'b1, 2'b10, 1'b0, 12'h100, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0, t0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_mem_we", 32'(mem_we), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_ram_100", 32'(ram[12'h100]), 32'h0D);
        check("abort_ram_101", 32'(ram[12'h101]), 32'hF0);
        check("abort_ram_102", 32'(ram[12'h102]), 32'h00);
        check("abort_ram_103", 32'(ram[12'h103]), 32'h00);
        issue("ld_after_abort", 1'b0, 2'b10, 1'b0, 12'h100, 32'd0, 32'h0000_F00D, 1'b0, 1'b0, t0);
        wait_done("ld_after_abort");

        // Back-to-back with req_valid held; second fields appear mid-operation
        issue("b2b_a", 1'b0, 2'b10, 1'b0, 12'h010, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b1, t0);
        issue("b2b_b", 1'b0, 2'b00, 1'b1, 12'h005, 32'd0, 32'hFFFF_FF80, 1'b0, 1'b0, t1);
        check("b2b_gap", 32'(t1 - t0), 32'd7);
        wait_done("b2b");

        check("ready_while_busy", 32'(busy_ready), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
